temp_display_scheduler: RTL and testbench

Sits between the I2C temperature reader and the 4-digit seven-segment driver. Captures each temperature sample and tracks current, minimum and maximum values. Time-multiplexes the single display between CUR, MIN and MAX views on a dwell timer, with a manual "next" override. Flags a stale sensor when samples stop arriving.

---
 rtl/temp_disp_pkg.sv | 26 ++
 rtl/temp_display_scheduler_ms_tick_gen.sv | 28 ++
 rtl/temp_display_scheduler.sv | 125 ++++++++++++
 tb/tb_temp_display_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_disp_pkg.sv
// Shared constants for the temperature display scheduler: view states, display mode codes, data width.
// Latency: none (declarations only).  Backpressure: not applicable.
package temp_disp_pkg;

    localparam int TEMP_W = 8;

    localparam logic [2:0] ST_EMPTY = 3'd0;
    localparam logic [2:0] ST_CUR   = 3'd1;
    localparam logic [2:0] ST_MIN   = 3'd2;
    localparam logic [2:0] ST_MAX   = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;

    localparam logic [1:0] MODE_CUR   = 2'b00;
    localparam logic [1:0] MODE_MIN   = 2'b01;
    localparam logic [1:0] MODE_MAX   = 2'b10;
    localparam logic [1:0] MODE_ALARM = 2'b11;

    function automatic logic [2:0] next_view(input logic [2:0] s);
        case (s)
            ST_CUR:  return ST_MIN;
            ST_MIN:  return ST_MAX;
            default: return ST_CUR;
        endcase
    endfunction

endpackage

// File: rtl/temp_display_scheduler_ms_tick_gen.sv
// Millisecond strobe generator: free-running prescaler, one-cycle pulse at terminal count.
// Latency: first tick CLK_HZ/1000 cycles after reset.  Backpressure: none, strobe is unconditional.
module ms_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk_50MHz,
    input  logic rst_n,
    output logic ms_tick
);

    localparam int TC = CLK_HZ / 1000 - 1;
    localparam int W  = (TC > 0) ? $clog2(TC + 1) : 1;

    logic [W-1:0] presc_cnt;

    assign ms_tick = (presc_cnt == W'(TC));

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (ms_tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/temp_display_scheduler.sv
// Tracks cur/min/max temperature and rotates the display view on a dwell timer; flags a stale sensor.
// Latency: display reflects a sample one cycle after capture.  Backpressure: none. Optional TEMP_ALARM_EN.
module temp_display_scheduler
    import temp_disp_pkg::*;
#(
    parameter int               CLK_HZ   = 50_000_000,
    parameter int               DWELL_MS = 2000,
    parameter int               STALE_MS = 1000,
    parameter logic [TEMP_W-1:0] ALARM_HI = 8'd40
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample_data,
    input  logic              btn_next,
    input  logic              btn_clr,
    output logic [TEMP_W-1:0] disp_data,
    output logic [1:0]        disp_mode,
    output logic              disp_blank,
    output logic              stale
);

    localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int SW = $clog2(STALE_MS + 1);

    logic              ms_tick;
    logic [2:0]        state;
    logic [TEMP_W-1:0] cur_t, min_t, max_t;
    logic [DW-1:0]     dwell_cnt;
    logic [SW-1:0]     stale_cnt;
    logic              rotating, dwell_exp, advance;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .ms_tick   (ms_tick)
    );

    assign rotating  = (state == ST_CUR) || (state == ST_MIN) || (state == ST_MAX);
    assign dwell_exp = ms_tick && (dwell_cnt == DW'(DWELL_MS - 1));
    // Button and expiry on the same cycle collapse into a single advance.
    assign advance   = rotating && (btn_next || dwell_exp);

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            cur_t     <= '0;
            min_t     <= '0;
            max_t     <= '0;
            dwell_cnt <= '0;
            stale_cnt <= '0;
        end else begin
            if (state == ST_EMPTY) begin
                dwell_cnt <= '0;
                if (sample_valid) state <= ST_CUR;
            end else begin
                if (advance) begin
                    state     <= next_view(state);
                    dwell_cnt <= '0;
                end else if (rotating && ms_tick) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
`ifdef TEMP_ALARM_EN
                // Alarm entry overrides any rotation step taken on the same edge.
                if (sample_valid && (sample_data >= ALARM_HI)) begin
                    state <= ST_ALARM;
                end else if ((state == ST_ALARM) && sample_valid &&
                             (sample_data < (ALARM_HI - 8'd2))) begin
                    state     <= ST_CUR;
                    dwell_cnt <= '0;
                end
`endif
            end

            if (sample_valid) begin
                cur_t <= sample_data;
                if ((state == ST_EMPTY) || btn_clr) begin
                    min_t <= sample_data;
                    max_t <= sample_data;
                end else begin
                    if (sample_data < min_t) min_t <= sample_data;
                    if (sample_data > max_t) max_t <= sample_data;
                end
            end else if (btn_clr && (state != ST_EMPTY)) begin
                min_t <= cur_t;
                max_t <= cur_t;
            end

            if (sample_valid) begin
                stale_cnt <= '0;
            end else if ((state != ST_EMPTY) && ms_tick && (stale_cnt != SW'(STALE_MS))) begin
                stale_cnt <= stale_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        disp_data = cur_t;
        disp_mode = MODE_CUR;
        case (state)
            ST_MIN: begin
                disp_data = min_t;
                disp_mode = MODE_MIN;
            end
            ST_MAX: begin
                disp_data = max_t;
                disp_mode = MODE_MAX;
            end
`ifdef TEMP_ALARM_EN
            ST_ALARM: begin
                disp_data = cur_t;
                disp_mode = MODE_ALARM;
            end
`endif
            default: begin
                disp_data = cur_t;
                disp_mode = MODE_CUR;
            end
        endcase
    end

    assign disp_blank = (state == ST_EMPTY);
    assign stale      = (stale_cnt == SW'(STALE_MS));

endmodule

// File: tb/tb_temp_display_scheduler.sv
// Directed bench for temp_display_scheduler at CLK_HZ=10_000 (10 cycles/ms), DWELL_MS=3, STALE_MS=5.
module tb_temp_display_scheduler;
    import temp_disp_pkg::*;

    logic       clk_50MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'd0;
    logic       btn_next = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] disp_data;
    logic [1:0] disp_mode;
    logic       disp_blank;
    logic       stale;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    temp_display_scheduler #(
        .CLK_HZ   (10_000),
        .DWELL_MS (3),
        .STALE_MS (5),
        .ALARM_HI (8'd40)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .btn_next     (btn_next),
        .btn_clr      (btn_clr),
        .disp_data    (disp_data),
        .disp_mode    (disp_mode),
        .disp_blank   (disp_blank),
        .stale        (stale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic sample(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        idle(1);
        sample_valid = 1'b0;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        idle(1);
        btn_next = 1'b0;
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        idle(1);
        btn_clr = 1'b0;
    endtask

    task automatic show(input string tag, input logic [1:0] m, input logic [7:0] d);
        check({tag, "_mode"}, 32'(disp_mode), 32'(m));
        check({tag, "_data"}, 32'(disp_data), 32'(d));
    endtask

    // Returns the number of edges until disp_mode changes (capped at 100).
    task automatic wait_mode_change(output int n);
        logic [1:0] m0;
        m0 = disp_mode;
        n  = 0;
        while ((disp_mode == m0) && (n < 100)) begin
            idle(1);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] exp_d;

        // Reset and idle: blank, buttons ignored.
        do_reset();
        check("rst_blank", 32'(disp_blank), 32'd1);
        show("rst", MODE_CUR, 8'd0);
        check("rst_stale", 32'(stale), 32'd0);
        idle(100);
        press_next();
        press_next();
        press_clr();
        check("empty_blank", 32'(disp_blank), 32'd1);
        show("empty", MODE_CUR, 8'd0);
        check("empty_stale", 32'(stale), 32'd0);

        // Manual rotation over cur/min/max.
        sample(8'd25);
        check("s1_blank", 32'(disp_blank), 32'd0);
        show("s1_cur", MODE_CUR, 8'd25);
        sample(8'd30);
        sample(8'd20);
        show("s2_cur", MODE_CUR, 8'd20);
        press_next();
        show("s2_min", MODE_MIN, 8'd20);
        press_next();
        show("s2_max", MODE_MAX, 8'd30);
        press_next();
        show("s2_wrap", MODE_CUR, 8'd20);
`ifndef TEMP_ALARM_EN
        sample(8'd200);
        show("s2_big_cur", MODE_CUR, 8'd200);
        press_next();
        show("s2_big_min", MODE_MIN, 8'd20);
        press_next();
        show("s2_big_max", MODE_MAX, 8'd200);
`endif

        // Auto-advance on dwell, button on the expiry cycle.
        do_reset();
        sample(8'd22);
        wait_mode_change(n);
        check("s3_first_dwell_in_range", 32'((n >= 21) && (n <= 30)), 32'd1);
        check("s3_to_min", 32'(disp_mode), 32'(MODE_MIN));
        wait_mode_change(n);
        check("s3_dwell_cycles", 32'(n), 32'd30);
        check("s3_to_max", 32'(disp_mode), 32'(MODE_MAX));
        idle(29);
        press_next();
        check("s3_single_advance", 32'(disp_mode), 32'(MODE_CUR));
        idle(29);
        check("s3_dwell_restart_hold", 32'(disp_mode), 32'(MODE_CUR));
        idle(1);
        check("s3_dwell_restart_adv", 32'(disp_mode), 32'(MODE_MIN));

        // Clear of min/max, clear coinciding with a sample, reset discards history.
        do_reset();
        sample(8'd18);
        sample(8'd35);
        press_next();
        show("s4_min", MODE_MIN, 8'd18);
        press_clr();
        show("s4_clr_min", MODE_MIN, 8'd35);
        press_next();
        show("s4_clr_max", MODE_MAX, 8'd35);
        sample_valid = 1'b1;
        sample_data  = 8'd27;
        btn_clr      = 1'b1;
        idle(1);
        sample_valid = 1'b0;
        btn_clr      = 1'b0;
        show("s4_both_max", MODE_MAX, 8'd27);
        press_next();
        show("s4_both_cur", MODE_CUR, 8'd27);
        press_next();
        show("s4_both_min", MODE_MIN, 8'd27);
        do_reset();
        check("s4_rst_blank", 32'(disp_blank), 32'd1);
        show("s4_rst", MODE_CUR, 8'd0);
        sample(8'd30);
        press_next();
        show("s4_fresh_min", MODE_MIN, 8'd30);
        press_next();
        show("s4_fresh_max", MODE_MAX, 8'd30);

        // Stale detection and saturation.
        do_reset();
        sample(8'd22);
        check("s5_stale_initial", 32'(stale), 32'd0);
        idle(30);
        check("s5_stale_early", 32'(stale), 32'd0);
        idle(20);
        check("s5_stale_set", 32'(stale), 32'd1);
        check("s5_stale_data", 32'(disp_data), 32'd22);
        idle(30);
        check("s5_stale_held", 32'(stale), 32'd1);
        sample(8'd23);
        check("s5_stale_cleared", 32'(stale), 32'd0);
        exp_d = (disp_mode == MODE_MIN) ? 8'd22 : 8'd23;
        check("s5_new_data", 32'(disp_data), 32'(exp_d));

`ifdef TEMP_ALARM_EN
        // Over-temperature alarm with 2 degree hysteresis.
        do_reset();
        sample(8'd30);
        sample(8'd41);
        show("s6_alarm", MODE_ALARM, 8'd41);
        press_next();
        show("s6_next_ignored", MODE_ALARM, 8'd41);
        sample(8'd39);
        show("s6_hyst_39", MODE_ALARM, 8'd39);
        sample(8'd38);
        show("s6_hyst_38", MODE_ALARM, 8'd38);
        sample(8'd37);
        show("s6_exit", MODE_CUR, 8'd37);
        wait_mode_change(n);
        check("s6_dwell_restart", 32'((n >= 21) && (n <= 30)), 32'd1);
        sample(8'd40);
        show("s6_alarm_at_thr", MODE_ALARM, 8'd40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
